spin_motor_ramp: RTL and testbench

Consumer end of the spin-speed selection path. Takes the 11-bit selected spin speed (rpm), ramps the drum motor speed command up to it in fixed steps, holds for a programmed time, then ramps down to zero and reports completion. It sits between the spin-speed selector and the motor drive interface.

---
 rtl/spin_pkg.sv | 22 ++
 rtl/rpm_tick_prescaler.sv | 29 ++
 rtl/spin_motor_ramp.sv | 135 +++++++++++++
 tb/tb_spin_motor_ramp.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spin_pkg.sv
// rtl/spin_pkg.sv - shared types and constants for the spin motor ramp
package spin_pkg;

  localparam int RPM_W           = 11;
  localparam int DEFAULT_MAX_RPM = 1400;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } spin_state_e;

  // One bit wider than the rpm bus so step sums and differences cannot wrap
  typedef logic [RPM_W:0] rpm_ext_t;

  function automatic logic [RPM_W-1:0] clamp_rpm(input logic [RPM_W-1:0] rpm,
                                                 input logic [RPM_W-1:0] max_rpm);
    return (rpm > max_rpm) ? max_rpm : rpm;
  endfunction

endpackage

// File: rtl/rpm_tick_prescaler.sv
// rtl/rpm_tick_prescaler.sv - divides clk into one tick every TICK_DIV cycles, restartable by clear_i
module rpm_tick_prescaler #(
  parameter int TICK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Not gated by clear_i: the owner derives clear_i from a decision that uses tick_o
  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/spin_motor_ramp.sv
// rtl/spin_motor_ramp.sv - drum motor ramp-up / hold / ramp-down sequencer; SPIN_DOOR_INTERLOCK_EN adds door_open
module spin_motor_ramp
  import spin_pkg::*;
#(
  parameter int STEP_RPM   = 50,
  parameter int TICK_DIV   = 2,
  parameter int HOLD_TICKS = 30,
  parameter int MAX_RPM    = DEFAULT_MAX_RPM
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop_req,
`ifdef SPIN_DOOR_INTERLOCK_EN
  input  logic             door_open,
`endif
  input  logic [RPM_W-1:0] target_rpm,
  output logic [RPM_W-1:0] motor_rpm,
  output logic             busy,
  output logic             at_speed,
  output logic             spin_done,
  output logic [1:0]       state
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam rpm_ext_t         STEP      = rpm_ext_t'(STEP_RPM);
  localparam logic [RPM_W-1:0] MAX_CAP   = RPM_W'(MAX_RPM);

  spin_state_e      state_q, state_d;
  logic [RPM_W-1:0] rpm_q, rpm_d;
  logic [RPM_W-1:0] tgt_q, tgt_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             done_q, done_d;
  logic             busy_q, at_speed_q;
  logic             tick, clear, abort;
  rpm_ext_t         up_gap, up_sum, down_diff;

`ifdef SPIN_DOOR_INTERLOCK_EN
  assign abort = stop_req | door_open;
`else
  assign abort = stop_req;
`endif

  assign up_gap    = rpm_ext_t'(tgt_q) - rpm_ext_t'(rpm_q);
  assign up_sum    = rpm_ext_t'(rpm_q) + STEP;
  assign down_diff = rpm_ext_t'(rpm_q) - STEP;

  always_comb begin
    state_d = state_q;
    rpm_d   = rpm_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          tgt_d = clamp_rpm(target_rpm, MAX_CAP);
          if (clamp_rpm(target_rpm, MAX_CAP) != '0) state_d = RAMP_UP;
          else                                      done_d  = 1'b1;
        end
      end
      RAMP_UP: begin
        if (abort) begin
          state_d = RAMP_DOWN;
        end else if (tick) begin
          if (up_gap > STEP) begin
            rpm_d = up_sum[RPM_W-1:0];
          end else begin
            rpm_d   = tgt_q;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = RAMP_DOWN;
        end else if (tick) begin
          if (hold_q == HOLD_LAST) state_d = RAMP_DOWN;
          else                     hold_d  = hold_q + 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (tick) begin
          if (rpm_ext_t'(rpm_q) > STEP) begin
            rpm_d = down_diff[RPM_W-1:0];
          end else begin
            rpm_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != HOLD) hold_d = '0;
  end

  // Restart the tick phase on every state change so the first step is a full period away
  assign clear = (state_d != state_q);

  rpm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rpm_q      <= '0;
      tgt_q      <= '0;
      hold_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      at_speed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rpm_q      <= rpm_d;
      tgt_q      <= tgt_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      busy_q     <= (state_d != IDLE);
      at_speed_q <= (state_d == HOLD);
    end
  end

  assign motor_rpm = rpm_q;
  assign busy      = busy_q;
  assign at_speed  = at_speed_q;
  assign spin_done = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_spin_motor_ramp.sv
// tb/tb_spin_motor_ramp.sv - directed self-checking bench for spin_motor_ramp
module tb_spin_motor_ramp;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop_req;
  logic [10:0] target_rpm;
  logic [10:0] motor_rpm;
  logic        busy;
  logic        at_speed;
  logic        spin_done;
  logic [1:0]  state;
`ifdef SPIN_DOOR_INTERLOCK_EN
  logic        door_open;
`endif

  int errors = 0;
  int checks = 0;

  spin_motor_ramp #(
    .STEP_RPM   (50),
    .TICK_DIV   (2),
    .HOLD_TICKS (4),
    .MAX_RPM    (1400)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop_req   (stop_req),
`ifdef SPIN_DOOR_INTERLOCK_EN
    .door_open  (door_open),
`endif
    .target_rpm (target_rpm),
    .motor_rpm  (motor_rpm),
    .busy       (busy),
    .at_speed   (at_speed),
    .spin_done  (spin_done),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ramp_up(input int tgt, output int steps);
    int exp;
    exp   = 0;
    steps = 0;
    while (exp != tgt && steps < 64) begin
      cyc(2);
      steps++;
      exp = (tgt - exp > 50) ? exp + 50 : tgt;
      check("up_rpm", motor_rpm, exp);
      check("up_state", state, (exp == tgt) ? 2 : 1);
    end
    check("up_at_speed", at_speed, 1);
  endtask

  task automatic ramp_down(input int from);
    int exp;
    int n;
    exp = from;
    n   = 0;
    while (exp != 0 && n < 64) begin
      cyc(2);
      n++;
      exp = (exp > 50) ? exp - 50 : 0;
      check("down_rpm", motor_rpm, exp);
      check("down_state", state, (exp == 0) ? 0 : 3);
    end
    check("done_pulse", spin_done, 1);
    check("done_busy", busy, 0);
    cyc(1);
    check("done_clear", spin_done, 0);
  endtask

  task automatic pulse_start(input int tgt);
    target_rpm = 11'(tgt);
    start      = 1'b1;
    cyc(1);
    start      = 1'b0;
  endtask

  initial begin
    int steps;
    reset      = 1'b1;
    start      = 1'b0;
    stop_req   = 1'b0;
    target_rpm = '0;
`ifdef SPIN_DOOR_INTERLOCK_EN
    door_open  = 1'b0;
`endif
    cyc(3);
    check("rst_rpm", motor_rpm, 0);
    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_at_speed", at_speed, 0);
    check("rst_done", spin_done, 0);
    reset = 1'b0;
    cyc(1);

    // 400 rpm: 8 steps up, 8 cycles hold, 8 steps down
    pulse_start(400);
    check("s1_state", state, 1);
    check("s1_busy", busy, 1);
    check("s1_rpm0", motor_rpm, 0);
    ramp_up(400, steps);
    check("s1_steps", steps, 8);
    cyc(7);
    check("s1_hold_state", state, 2);
    check("s1_hold_at_speed", at_speed, 1);
    cyc(1);
    check("s1_rd_state", state, 3);
    check("s1_rd_at_speed", at_speed, 0);
    check("s1_rd_rpm", motor_rpm, 400);
    ramp_down(400);

    // 425 rpm: last step is partial; target changes after latch are ignored
    pulse_start(425);
    target_rpm = 11'd100;
    ramp_up(425, steps);
    check("s2_steps", steps, 9);
    cyc(8);
    check("s2_rd_state", state, 3);
    ramp_down(425);

    // 1600 clamps to 1400
    pulse_start(1600);
    ramp_up(1400, steps);
    check("s3_steps", steps, 28);
    cyc(8);
    check("s3_rd_rpm", motor_rpm, 1400);
    ramp_down(1400);

    // stop at 200 during ramp-up; starts during ramp-down are ignored
    pulse_start(400);
    cyc(8);
    check("s4_rpm200", motor_rpm, 200);
    check("s4_state_up", state, 1);
    stop_req = 1'b1;
    cyc(1);
    stop_req = 1'b0;
    check("s4_stop_state", state, 3);
    check("s4_stop_rpm", motor_rpm, 200);
    target_rpm = 11'd600;
    start      = 1'b1;
    cyc(1);
    start      = 1'b0;
    check("s4_hold_rpm", motor_rpm, 200);
    check("s4_state_rd", state, 3);
    cyc(1);
    check("s4_rpm150", motor_rpm, 150);
    ramp_down(150);

    // reset during hold, stop-vs-start priority, zero target
    pulse_start(400);
    ramp_up(400, steps);
    cyc(3);
    check("s5_hold", state, 2);
    reset = 1'b1;
    #1;
    check("s5_rst_rpm", motor_rpm, 0);
    check("s5_rst_state", state, 0);
    check("s5_rst_done", spin_done, 0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("s5_no_done", spin_done, 0);
    stop_req = 1'b1;
    pulse_start(400);
    stop_req = 1'b0;
    check("s5_stop_wins_state", state, 0);
    check("s5_stop_wins_busy", busy, 0);
    check("s5_stop_wins_done", spin_done, 0);
    pulse_start(0);
    check("s5_zero_done", spin_done, 1);
    check("s5_zero_state", state, 0);
    check("s5_zero_busy", busy, 0);
    cyc(1);
    check("s5_zero_done_clr", spin_done, 0);

`ifdef SPIN_DOOR_INTERLOCK_EN
    door_open = 1'b1;
    pulse_start(400);
    check("s6_door_block_state", state, 0);
    check("s6_door_block_done", spin_done, 0);
    door_open = 1'b0;
    cyc(1);
    pulse_start(400);
    ramp_up(400, steps);
    cyc(2);
    door_open = 1'b1;
    cyc(1);
    door_open = 1'b0;
    check("s6_door_state", state, 3);
    check("s6_door_rpm", motor_rpm, 400);
    ramp_down(400);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
